byte_stream_shift_sequencer: RTL and testbench

//  Shifts an NBYTES-byte operand left by 0..8*NBYTES-1 bits, streaming the operand in and
//  the result out one byte per cycle, LSB byte first. Sequences one 8-bit funnel barrel shifter:

---
 rtl/shift_seq_pkg.sv | 14 +
 rtl/left_barrel_shifter_x7_8b.sv | 18 +
 rtl/byte_stream_shift_sequencer.sv | 143 ++++++++++++++
 tb/tb_byte_stream_shift_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types for the byte-stream shift sequencer: sequencer states and the byte width.
package shift_seq_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ZERO  = 3'd1,
      SHIFT = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/left_barrel_shifter_x7_8b.sv
// 8-bit funnel left shifter, 0..7 bits: low bits of dout are filled from the top of cin,
// and the bits pushed out of din appear in cout.
module left_barrel_shifter_x7_8b
   import shift_seq_pkg::*;
(
   input  logic [BYTE_W-1:0] din,
   input  logic [BYTE_W-1:0] cin,
   input  logic [2:0]        sh,
   output logic [BYTE_W-1:0] dout,
   output logic [BYTE_W-1:0] cout
);

   // The bottom byte is cin shifted left, which is discarded.
   logic [BYTE_W-1:0] unused_low;

   assign {cout, dout, unused_low} = {{BYTE_W{1'b0}}, din, cin} << sh;

endmodule

// File: rtl/byte_stream_shift_sequencer.sv
// Streams an NBYTES-byte operand through an 8-bit funnel shifter, LSB byte first, producing
// the operand shifted left by shamt; whole-byte shifts become leading zero bytes.
module byte_stream_shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter  int NBYTES = 4,
   localparam int SHW    = $clog2(8 * NBYTES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [SHW-1:0]    shamt,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BYTE_W-1:0] in_byte,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BYTE_W-1:0] out_byte,
   output logic              done,
   output logic              ovf
);

   localparam int QW = SHW - 3;
   localparam int CW = $clog2(NBYTES + 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] NB_CNT  = CW'(NBYTES);

   state_t            state;
   logic [QW-1:0]     q;
   logic [2:0]        b;
   logic [BYTE_W-1:0] prev;
   logic [CW-1:0]     cnt;
   logic              ovf_r;

   logic [BYTE_W-1:0] sh_out;
   logic [BYTE_W-1:0] sh_cout;
   logic [CW-1:0]     q_cnt;
   logic              in_xfer;
   logic              out_xfer;
   logic              zero_last;
   logic              shift_last;
   logic              drain_last;

   left_barrel_shifter_x7_8b u_shifter (
      .din  (in_byte),
      .cin  (prev),
      .sh   (b),
      .dout (sh_out),
      .cout (sh_cout)
   );

   assign q_cnt      = CW'(q);
   assign in_xfer    = in_valid & in_ready;
   assign out_xfer   = out_valid & out_ready;
   assign zero_last  = (cnt == q_cnt - CNT_ONE);
   assign shift_last = (cnt == NB_CNT - q_cnt - CNT_ONE);
   assign drain_last = (cnt == q_cnt - CNT_ONE);

   assign busy = (state != IDLE);
   assign done = (state == DONE);
   assign ovf  = ovf_r;

   // SHIFT is a zero-latency pass-through, so the source only advances when the sink takes a byte.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_byte  = '0;
      case (state)
         ZERO: out_valid = 1'b1;
         SHIFT: begin
            out_valid = in_valid;
            in_ready  = out_ready;
            out_byte  = sh_out;
         end
         DRAIN: in_ready = 1'b1;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register updates together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         q     <= '0;
         b     <= '0;
         prev  <= '0;
         cnt   <= '0;
         ovf_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  q     <= shamt[SHW-1:3];
                  b     <= shamt[2:0];
                  prev  <= '0;
                  cnt   <= '0;
                  ovf_r <= 1'b0;
                  state <= (shamt[SHW-1:3] != '0) ? ZERO : SHIFT;
               end
            end
            ZERO: begin
               if (out_xfer) begin
                  if (zero_last) begin
                     cnt   <= '0;
                     state <= SHIFT;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
            end
            SHIFT: begin
               if (in_xfer) begin
                  prev <= in_byte;
                  if (shift_last) begin
                     cnt   <= '0;
                     ovf_r <= ovf_r | (sh_cout != '0);
                     state <= (q != '0) ? DRAIN : DONE;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
            end
            // Drained bytes would land above the result; any set bit there is an overflow.
            DRAIN: begin
               if (in_xfer) begin
                  ovf_r <= ovf_r | (in_byte != '0);
                  if (drain_last) begin
                     cnt   <= '0;
                     state <= DONE;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_byte_stream_shift_sequencer.sv
// Directed bench for byte_stream_shift_sequencer (NBYTES=4): shift vectors, backpressure,
// ignored start, overflow hold and mid-operation reset.
module tb_byte_stream_shift_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [4:0] shamt;
   logic       busy;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_byte;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_byte;
   logic       done;
   logic       ovf;

   int vectors     = 0;
   int miscompares = 0;

   byte_stream_shift_sequencer #(.NBYTES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .shamt     (shamt),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_byte   (in_byte),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_byte  (out_byte),
      .done      (done),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  sh;
      logic [31:0] op;
      logic [31:0] exp;
      logic        ovf;
   } vec_t;

   // Runs one operation from IDLE (called at posedge+1); returns what the sink observed.
   task automatic do_op(input logic [4:0] sh, input logic [31:0] opnd,
                        input int stall_from, input int stall_len, input logic hold_start,
                        output logic [31:0] got, output int nin, output int nout,
                        output logic ovf_at_done, output logic ovf_after_start,
                        output logic timing_ok, output logic stall_ok, output logic timed_out);
      int last_in;
      got = '0; nin = 0; nout = 0; ovf_at_done = 1'b0; ovf_after_start = 1'b1;
      timing_ok = 1'b0; stall_ok = 1'b1; timed_out = 1'b1; last_in = -10;
      start = 1'b1; shamt = sh; in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      start = hold_start;
      shamt = hold_start ? ~sh : sh;
      for (int cyc = 0; cyc < 40; cyc++) begin
         in_valid  = (nin < 4);
         in_byte   = 8'(opnd >> (8 * nin));
         out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
         #1;
         if (cyc == 0) ovf_after_start = ovf;
         if (done) begin
            timed_out   = 1'b0;
            ovf_at_done = ovf;
            timing_ok   = (last_in == cyc - 1);
            start       = 1'b0;
            break;
         end
         if (!out_ready && in_ready) stall_ok = 1'b0;
         if (in_valid && in_ready) begin
            nin++;
            last_in = cyc;
         end
         if (out_valid && out_ready) begin
            if (nout < 4) got[8*nout +: 8] = out_byte;
            nout++;
         end
         @(posedge clk); #1;
      end
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; shamt = '0; in_valid = 1'b1; in_byte = 8'hA5; out_ready = 1'b1;
      #3;
      vectors++;
      if ({busy, in_ready, out_valid, done, ovf, out_byte} !== 13'h0) begin
         miscompares++;
         $display("FAIL reset_state: got %h, expected 0", {busy, in_ready, out_valid, done, ovf, out_byte});
      end
      #4 rst_n = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_shift_vectors();
      vec_t tbl[9];
      logic [31:0] got;
      int nin, nout;
      logic ovf_d, ovf_s, tim_ok, st_ok, tmo;
      tbl[0] = '{5'd0,  32'h11223344, 32'h11223344, 1'b0};
      tbl[1] = '{5'd4,  32'h11223344, 32'h12233440, 1'b1};
      tbl[2] = '{5'd10, 32'h11223344, 32'h88CD1000, 1'b1};
      tbl[3] = '{5'd31, 32'h00000001, 32'h80000000, 1'b0};
      tbl[4] = '{5'd7,  32'h01FFFFFF, 32'hFFFFFF80, 1'b0};
      tbl[5] = '{5'd8,  32'h11223344, 32'h22334400, 1'b1};
      tbl[6] = '{5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
      tbl[7] = '{5'd24, 32'h01000000, 32'h00000000, 1'b1};
      tbl[8] = '{5'd16, 32'h0000ABCD, 32'hABCD0000, 1'b0};
      for (int i = 0; i < 9; i++) begin
         do_op(tbl[i].sh, tbl[i].op, 100, 0, 1'b0, got, nin, nout, ovf_d, ovf_s, tim_ok, st_ok, tmo);
         vectors++;
         if (tmo !== 1'b0) begin
            miscompares++;
            $display("FAIL vec%0d_timeout: done not seen within 40 cycles", i);
         end
         vectors++;
         if (got !== tbl[i].exp) begin
            miscompares++;
            $display("FAIL vec%0d_result: got %h, expected %h", i, got, tbl[i].exp);
         end
         vectors++;
         if (ovf_d !== tbl[i].ovf) begin
            miscompares++;
            $display("FAIL vec%0d_ovf: got %b, expected %b", i, ovf_d, tbl[i].ovf);
         end
         vectors++;
         if (nin !== 4 || nout !== 4) begin
            miscompares++;
            $display("FAIL vec%0d_counts: got in=%0d out=%0d, expected in=4 out=4", i, nin, nout);
         end
         vectors++;
         if (tim_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL vec%0d_done_timing: got %b, expected done one cycle after last input", i, tim_ok);
         end
         @(posedge clk); #1;
         vectors++;
         if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL vec%0d_done_pulse: got done,busy=%b, expected 00", i, {done, busy});
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] got;
      int nin, nout;
      logic ovf_d, ovf_s, tim_ok, st_ok, tmo;
      // cycle 0 is ZERO, SHIFT starts at 1; stall cycles 2..4 sit inside SHIFT.
      do_op(5'd10, 32'h11223344, 2, 3, 1'b0, got, nin, nout, ovf_d, ovf_s, tim_ok, st_ok, tmo);
      vectors++;
      if (got !== 32'h88CD1000 || tmo !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_result: got %h (timeout=%b), expected 88cd1000", got, tmo);
      end
      vectors++;
      if (st_ok !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_in_ready: got in_ready high while out_ready low, expected low");
      end
      vectors++;
      if (ovf_d !== 1'b1 || nin !== 4 || nout !== 4) begin
         miscompares++;
         $display("FAIL bp_ovf_counts: got ovf=%b in=%0d out=%0d, expected 1 4 4", ovf_d, nin, nout);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_start_ignored();
      logic [31:0] got;
      int nin, nout;
      logic ovf_d, ovf_s, tim_ok, st_ok, tmo;
      do_op(5'd4, 32'h11223344, 100, 0, 1'b1, got, nin, nout, ovf_d, ovf_s, tim_ok, st_ok, tmo);
      vectors++;
      if (got !== 32'h12233440 || ovf_d !== 1'b1 || tmo !== 1'b0) begin
         miscompares++;
         $display("FAIL start_ignored: got %h ovf=%b, expected 12233440 ovf=1", got, ovf_d);
      end
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL start_ignored_idle: got busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_ovf_hold();
      logic [31:0] got;
      int nin, nout;
      logic ovf_d, ovf_s, tim_ok, st_ok, tmo;
      do_op(5'd4, 32'h11223344, 100, 0, 1'b0, got, nin, nout, ovf_d, ovf_s, tim_ok, st_ok, tmo);
      in_valid = 1'b1;
      in_byte  = 8'h5A;
      repeat (5) @(posedge clk);
      #1;
      vectors++;
      if ({ovf, busy, in_ready, out_valid} !== 4'b1000) begin
         miscompares++;
         $display("FAIL ovf_hold: got ovf,busy,in_ready,out_valid=%b, expected 1000", {ovf, busy, in_ready, out_valid});
      end
      in_valid = 1'b0;
      do_op(5'd0, 32'h11223344, 100, 0, 1'b0, got, nin, nout, ovf_d, ovf_s, tim_ok, st_ok, tmo);
      vectors++;
      if (ovf_s !== 1'b0 || ovf_d !== 1'b0 || got !== 32'h11223344) begin
         miscompares++;
         $display("FAIL ovf_clear: got start_ovf=%b done_ovf=%b result=%h, expected 0 0 11223344", ovf_s, ovf_d, got);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midop();
      logic [31:0] got;
      int nin, nout, taken;
      logic ovf_d, ovf_s, tim_ok, st_ok, tmo;
      logic [31:0] opnd = 32'h11223344;
      nin = 0; taken = 0;
      start = 1'b1; shamt = 5'd0;
      @(posedge clk); #1;
      start = 1'b0; out_ready = 1'b1;
      for (int cyc = 0; cyc < 10 && taken < 2; cyc++) begin
         in_valid = 1'b1;
         in_byte  = 8'(opnd >> (8 * nin));
         #1;
         if (in_valid && in_ready) nin++;
         if (out_valid && out_ready) taken++;
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, in_ready, out_valid, done, ovf, out_byte} !== 13'h0 || taken !== 2) begin
         miscompares++;
         $display("FAIL reset_midop: got %h after %0d outputs, expected 0 after 2",
                  {busy, in_ready, out_valid, done, ovf, out_byte}, taken);
      end
      #1 rst_n = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      do_op(5'd10, 32'h11223344, 100, 0, 1'b0, got, nin, nout, ovf_d, ovf_s, tim_ok, st_ok, tmo);
      vectors++;
      if (got !== 32'h88CD1000 || ovf_d !== 1'b1 || nin !== 4 || tmo !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_rerun: got %h ovf=%b in=%0d, expected 88cd1000 ovf=1 in=4", got, ovf_d, nin);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_shift_vectors();
      test_backpressure();
      test_start_ignored();
      test_ovf_hold();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
